// File: rtl/fifo_tx_ctrl.sv
// fifo_tx_ctrl: reader side of the result FIFO. Pops one byte per frame and
// hands it to the UART TX over a level valid/busy handshake.
//
// Ports:
//   CLK        clock
//   Reset      asynchronous active-low reset
//   Embty      FIFO empty flag
//   Data       FIFO read data, valid the cycle after a pop
//   valid      FIFO toggle flag, flips once per successful pop
//   ALU_valid  ALU write strobe to the FIFO (blocks popping)
//   RD_valid   register-file write strobe to the FIFO (blocks popping)
//   TX_busy    UART busy; rise acks the byte, fall ends the frame
//   RD_EN      FIFO pop request (combinational, one cycle wide)
//   TX_Data    byte presented to the UART (registered)
//   TX_valid   byte-available level to the UART (registered)
//   Busy       high whenever the controller is not idle
module fifo_tx_ctrl #(
    parameter int width = 8,
    parameter int GAP   = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Embty,
    input  logic [width-1:0] Data,
    input  logic             valid,
    input  logic             ALU_valid,
    input  logic             RD_valid,
    input  logic             TX_busy,
    output logic             RD_EN,
    output logic [width-1:0] TX_Data,
    output logic             TX_valid,
    output logic             Busy
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t        state_q;
    logic          valid_q;
    logic [GW-1:0] gcnt_q;
    logic          toggle;

    // The FIFO flips valid on every real pop; a missing flip means the pop
    // was lost and must be retried.
    assign toggle = valid ^ valid_q;

    // Pending FIFO writes always win over a pop; Reset gating keeps the
    // request low while the block is held in reset.
    assign RD_EN = Reset && (state_q == S_IDLE) && !Embty
                   && !ALU_valid && !RD_valid && !TX_busy;

    assign Busy = (state_q != S_IDLE);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            gcnt_q   <= '0;
            TX_Data  <= '0;
            TX_valid <= 1'b0;
        end else begin
            valid_q <= valid;
            unique case (state_q)
                S_IDLE: begin
                    if (RD_EN) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (toggle) begin
                        TX_Data  <= Data;
                        TX_valid <= 1'b1;
                        state_q  <= S_SEND;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (TX_busy) begin
                        TX_valid <= 1'b0;
                        state_q  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!TX_busy) begin
                        gcnt_q  <= GW'(GAP);
                        state_q <= (GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    gcnt_q <= gcnt_q - 1'b1;
                    if (gcnt_q <= GW'(1)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_tx_ctrl.md
# fifo_tx_ctrl

Reader side of the result FIFO. Pops one byte at a time from the FIFO, using the FIFO's toggle-style `valid`, and hands each byte to the UART transmitter over a level valid/busy handshake. It inserts a programmable idle gap between bytes. Sits between the result FIFO and the UART TX in the system block, and never reads while a FIFO write is pending.

## Interface
Parameters:
- `width`, 8, data byte width; matches the FIFO width.
- `GAP`, 2, idle cycles after TX_busy falls before the next pop; 0 allowed.

Ports:
- `CLK`  in  1  clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Embty`  in  1  FIFO empty flag.
- `Data`  in  width  FIFO read data; valid in the cycle after a pop.
- `valid`  in  1  FIFO toggle flag; flips once per successful pop.
- `ALU_valid`  in  1  ALU write strobe to the FIFO; blocks popping.
- `RD_valid`  in  1  register-file write strobe to the FIFO; blocks popping.
- `TX_busy`  in  1  UART TX busy; its rise is the ack, its fall marks the end of the frame.
- `RD_EN`  out  1  FIFO pop request; combinational, one cycle wide.
- `TX_Data`  out  width  byte presented to UART TX; registered.
- `TX_valid`  out  1  byte-available level to UART TX; registered.
- `Busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, FETCH, SEND, DRAIN, GAP. Internal registers: `valid_q` (valid delayed 1 cycle) and gap counter `gcnt` of width $clog2(GAP+1), minimum 1.
- `toggle = valid ^ valid_q`.
- IDLE:
  - `RD_EN = !Embty && !ALU_valid && !RD_valid && !TX_busy`; RD_EN is 0 in every other state.
  - If RD_EN = 1, go to FETCH.
- FETCH:
  - If toggle = 1: `TX_Data <= Data`, `TX_valid <= 1`, go to SEND.
  - If toggle = 0 (pop lost): go to IDLE to retry. No output change.
- SEND:
  - Hold TX_valid and TX_Data.
  - On TX_busy = 1: `TX_valid <= 0`, go to DRAIN.
- DRAIN: wait for TX_busy = 0, then load `gcnt <= GAP`. Go to GAP, or to IDLE if GAP = 0.
- GAP: decrement gcnt; go to IDLE in the cycle gcnt reaches 1.
- TX_Data holds its last value outside FETCH loads.
- Exactly one pop per transmitted byte. Bytes go out in FIFO order.
- A write strobe (ALU_valid/RD_valid) in the same cycle as a pop condition always wins: RD_EN stays 0. FIFO writes are never blocked by this block.
- Embty rising in any state other than IDLE has no effect. The current byte completes.

## Timing
- Reset values: state IDLE, TX_valid 0, TX_Data 0, valid_q 0, gcnt 0, Busy 0. RD_EN is 0 during reset.
- Reset mid-frame:
  - All registers return to reset values immediately.
  - A byte already popped but not sent is dropped.
  - valid_q resyncs to the FIFO's reset value 0.
- Latency:
  - RD_EN at cycle t, FIFO pops at edge t.
  - Toggle is seen in cycle t+1 (FETCH).
  - TX_valid is high from cycle t+2.
- Handshake:
  - TX_valid stays high until the first cycle TX_busy is sampled high, and drops the next cycle.
  - TX_Data is stable for the whole time TX_valid is high.
- Minimum spacing between RD_EN pulses is 3 + GAP + (TX_busy high cycles) + (cycles waiting for ack).
- If TX_busy is already high in IDLE, no pop occurs.

## Test plan
- **Single byte:** FIFO holds 0xA5, write strobes low, UART acks after 2 cycles and stays busy 10 cycles. Required: one RD_EN pulse; TX_Data = 0xA5 with TX_valid high 2 cycles after RD_EN; next RD_EN no earlier than GAP cycles after busy falls.
- **Burst order:** FIFO holds 0x11, 0x22, 0x33, 0x44. Required: transmitted sequence 0x11, 0x22, 0x33, 0x44; exactly 4 RD_EN pulses; Busy low and Embty high at the end.
- **Write collision:** ALU_valid held high for 3 cycles while the FIFO is non-empty. Required: RD_EN stays 0 during those cycles; pop happens the first cycle ALU_valid is low.
- **Lost pop:** force the FIFO's valid not to toggle after RD_EN. Required: FETCH returns to IDLE with TX_valid staying 0, and RD_EN is reissued.
- **Reset mid-SEND:** drop Reset while TX_valid = 1 with TX_Data = 0x5C. Required: TX_valid = 0, TX_Data = 0, Busy = 0 immediately; normal operation resumes after reset is released.
- **GAP = 0 build with 2 bytes:** Required: the second RD_EN is in the cycle right after TX_busy is sampled low.
